// File: rtl/cpu_alu.sv
// Single-cycle 19-bit unsigned ALU with registered result and 8-bit status flags.
// All operations, including the divider, are combinational; the outputs update only when aluen is set.
module cpu_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [18:0] r2,
  input  logic [18:0] r3,
  input  logic [2:0]  imm,
  input  logic        aluen,
  output logic [18:0] r1,
  output logic [7:0]  FLAG
);

  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_MUL  = 6'b000011;
  localparam logic [5:0] OP_DIV  = 6'b000100;
  localparam logic [5:0] OP_SHL  = 6'b000101;
  localparam logic [5:0] OP_SHR  = 6'b000110;
  localparam logic [5:0] OP_AND  = 6'b000111;
  localparam logic [5:0] OP_OR   = 6'b001000;
  localparam logic [5:0] OP_XOR  = 6'b001001;
  localparam logic [5:0] OP_XNOR = 6'b001010;
  localparam logic [5:0] OP_NOT  = 6'b001011;

  logic [18:0] r1_q, r1_d;
  logic [7:0]  flag_q, flag_d;

  logic [19:0] sum_w;
  logic [19:0] diff_w;
  logic [37:0] prod_w;
  logic [18:0] quot_w;
  logic [19:0] shl_w;
  logic [19:0] shr_w;

  logic carry, ovf, dz, inv;

  assign sum_w  = {1'b0, r2} + {1'b0, r3};
  assign diff_w = {1'b0, r2} - {1'b0, r3};
  assign prod_w = {19'b0, r2} * {19'b0, r3};
  assign quot_w = (r3 == '0) ? 19'h7FFFF : r2 / r3;
  // Bit 19 of the left shift and bit 0 of the right shift hold the last bit shifted out (0 when imm=0).
  assign shl_w  = {1'b0, r2} << imm;
  assign shr_w  = {r2, 1'b0} >> imm;

  always_comb begin
    r1_d  = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    dz    = 1'b0;
    inv   = 1'b0;
    unique case (opcode)
      OP_ADD: begin
        r1_d  = sum_w[18:0];
        carry = sum_w[19];
        ovf   = (r2[18] == r3[18]) && (sum_w[18] != r2[18]);
      end
      OP_SUB: begin
        r1_d  = diff_w[18:0];
        carry = diff_w[19];
        ovf   = (r2[18] != r3[18]) && (diff_w[18] != r2[18]);
      end
      OP_MUL: begin
        r1_d  = prod_w[18:0];
        carry = |prod_w[37:19];
      end
      OP_DIV: begin
        r1_d = quot_w;
        dz   = (r3 == '0);
      end
      OP_SHL: begin
        r1_d  = shl_w[18:0];
        carry = shl_w[19];
      end
      OP_SHR: begin
        r1_d  = shr_w[19:1];
        carry = shr_w[0];
      end
      OP_AND:  r1_d = r2 & r3;
      OP_OR:   r1_d = r2 | r3;
      OP_XOR:  r1_d = r2 ^ r3;
      OP_XNOR: r1_d = ~(r2 ^ r3);
      OP_NOT:  r1_d = ~r2;
      default: inv = 1'b1;
    endcase
    // Valid is set for an invalid opcode too: it still marks that an enabled operation happened.
    flag_d = {1'b1, inv, ^r1_d, dz, ovf, r1_d[18], carry, (r1_d == '0)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_q   <= '0;
      flag_q <= '0;
    end else if (aluen) begin
      r1_q   <= r1_d;
      flag_q <= flag_d;
    end
  end

  assign r1   = r1_q;
  assign FLAG = flag_q;

endmodule

// File: tb/tb_cpu_alu.sv
// Scoreboard bench for cpu_alu: the driver pushes expected outputs from an arithmetic reference model,
// a separate monitor pops and compares one entry after every rising edge.
module tb_cpu_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [18:0] r2, r3;
  logic [2:0]  imm;
  logic        aluen;
  logic [18:0] r1;
  logic [7:0]  FLAG;

  cpu_alu dut (
    .clk(clk), .reset(reset), .opcode(opcode), .r2(r2), .r3(r3),
    .imm(imm), .aluen(aluen), .r1(r1), .FLAG(FLAG)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [18:0] r1;
    logic [7:0]  flag;
  } exp_t;

  exp_t sb[$];
  int n_vec  = 0;
  int n_fail = 0;
  bit done   = 0;

  logic [18:0] m_r1;
  logic [7:0]  m_flag;

  localparam longint M    = 64'd524288;
  localparam longint HALF = 64'd262144;

  function automatic longint to_signed(input longint v);
    return (v >= HALF) ? v - M : v;
  endfunction

  // Reference: unsigned 19-bit semantics computed with wide integer arithmetic.
  function automatic void alu_ref(input logic [5:0] op, input longint a, input longint b,
                                  input int sh, output logic [18:0] res_o, output logic [7:0] fl_o);
    longint res, s, ss;
    bit c, ov, dz, inv, par;
    res = 0; c = 0; ov = 0; dz = 0; inv = 0;
    case (op)
      6'd1: begin
        s = a + b; res = s % M; c = (s >= M);
        ss = to_signed(a) + to_signed(b); ov = (ss >= HALF) || (ss < -HALF);
      end
      6'd2: begin
        s = a - b; res = (s + M) % M; c = (b > a);
        ss = to_signed(a) - to_signed(b); ov = (ss >= HALF) || (ss < -HALF);
      end
      6'd3: begin s = a * b; res = s % M; c = (s >= M); end
      6'd4: begin
        if (b == 0) begin res = M - 1; dz = 1; end
        else res = a / b;
      end
      6'd5: begin s = a << sh; res = s % M; c = ((s >> 19) & 1) != 0; end
      6'd6: begin res = a >> sh; c = (sh > 0) && (((a >> (sh - 1)) & 1) != 0); end
      6'd7:  res = a & b;
      6'd8:  res = a | b;
      6'd9:  res = a ^ b;
      6'd10: res = ~(a ^ b) & (M - 1);
      6'd11: res = ~a & (M - 1);
      default: inv = 1;
    endcase
    par = 0;
    for (int i = 0; i < 19; i++) par ^= ((res >> i) & 1) != 0;
    res_o = res[18:0];
    fl_o  = {1'b1, inv, par, dz, ov, (res >= HALF), c, (res == 0)};
  endfunction

  // One cycle of stimulus; use_c substitutes a hand-written expected r1 for directed cases.
  task automatic step(input string nm, input bit rst, input bit en, input logic [5:0] op,
                      input logic [18:0] a, input logic [18:0] b, input logic [2:0] sh,
                      input bit use_c, input logic [18:0] c_r1);
    logic [18:0] res;
    logic [7:0]  fl;
    exp_t e;
    reset = rst; aluen = en; opcode = op; r2 = a; r3 = b; imm = sh;
    if (rst) begin
      m_r1 = '0; m_flag = '0;
    end else if (en) begin
      alu_ref(op, longint'(a), longint'(b), int'(sh), res, fl);
      m_r1 = use_c ? c_r1 : res;
      m_flag = fl;
    end
    e.name = nm; e.r1 = m_r1; e.flag = m_flag;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic op_c(input string nm, input logic [5:0] op, input logic [18:0] a,
                      input logic [18:0] b, input logic [2:0] sh, input logic [18:0] c_r1);
    step(nm, 1'b0, 1'b1, op, a, b, sh, 1'b1, c_r1);
  endtask

  task automatic op_m(input string nm, input logic [5:0] op, input logic [18:0] a,
                      input logic [18:0] b, input logic [2:0] sh);
    step(nm, 1'b0, 1'b1, op, a, b, sh, 1'b0, 19'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (r1 !== e.r1 || FLAG !== e.flag) begin
          n_fail++;
          $display("FAIL %s: got r1=%05h FLAG=%02h, expected r1=%05h FLAG=%02h",
                   e.name, r1, FLAG, e.r1, e.flag);
        end
      end
    end
  end

  initial begin : driver
    logic [18:0] pa, pb;
    logic [5:0]  pop;
    pa = 19'b1010101010101010101;
    pb = 19'b1100110011001100110;

    step("reset", 1'b1, 1'b1, 6'd1, 19'd3, 19'd4, 3'd0, 1'b1, 19'd0);
    step("reset_hold", 1'b1, 1'b0, 6'd2, 19'd9, 19'd1, 3'd0, 1'b1, 19'd0);

    op_c("add_10_15", 6'd1, 19'd10, 19'd15, 3'd0, 19'd25);
    op_c("sub_20_5",  6'd2, 19'd20, 19'd5,  3'd0, 19'd15);
    op_c("mul_3_4",   6'd3, 19'd3,  19'd4,  3'd0, 19'd12);
    op_c("sub_5_20",  6'd2, 19'd5,  19'd20, 3'd0, 19'h7FFF1);
    op_c("div_40_8",  6'd4, 19'd40, 19'd8,  3'd0, 19'd5);
    op_c("div_by_0",  6'd4, 19'd10, 19'd0,  3'd0, 19'h7FFFF);
    op_c("and",  6'd7,  pa, pb, 3'd0, 19'b1000100010001000100);
    op_c("or",   6'd8,  pa, pb, 3'd0, 19'b1110111011101110111);
    op_c("xor",  6'd9,  pa, pb, 3'd0, 19'b0110011001100110011);
    op_c("xnor", 6'd10, pa, pb, 3'd0, 19'b1001100110011001100);
    op_c("not",  6'd11, pa, pb, 3'd0, 19'b0101010101010101010);
    op_c("invalid_3f", 6'b111111, 19'd123, 19'd456, 3'd2, 19'd0);
    step("hold_1", 1'b0, 1'b0, 6'd1, 19'd77, 19'd88, 3'd1, 1'b0, 19'd0);
    step("hold_2", 1'b0, 1'b0, 6'd3, 19'h7FFFF, 19'h7FFFF, 3'd7, 1'b0, 19'd0);

    op_c("add_wrap",  6'd1, 19'h7FFFF, 19'd1, 3'd0, 19'd0);
    op_c("add_ovf",   6'd1, 19'h3FFFF, 19'd1, 3'd0, 19'h40000);
    op_c("sub_ovf",   6'd2, 19'h40000, 19'd1, 3'd0, 19'h3FFFF);
    op_c("mul_big",   6'd3, 19'h7FFFF, 19'h7FFFF, 3'd0, 19'd1);
    op_c("shl_imm0",  6'd5, 19'h40001, 19'd0, 3'd0, 19'h40001);
    op_c("shl_imm7",  6'd5, 19'h7F001, 19'd0, 3'd7, 19'h00080);
    op_c("shr_imm1",  6'd6, 19'h00003, 19'd0, 3'd1, 19'h00001);
    op_c("shr_imm7",  6'd6, 19'h7FFFF, 19'd0, 3'd7, 19'h00FFF);
    op_c("opcode_0",  6'd0, 19'd5, 19'd5, 3'd0, 19'd0);

    op_m("pre_rst_op", 6'd1, 19'd100, 19'd200, 3'd0);
    step("rst_midseq", 1'b1, 1'b1, 6'd3, 19'd7, 19'd9, 3'd0, 1'b1, 19'd0);
    op_c("after_rst", 6'd1, 19'd1, 19'd2, 3'd0, 19'd3);

    for (int i = 0; i < 600; i++) begin
      pop = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(1, 11));
      case ($urandom_range(0, 3))
        0: begin pa = 19'($urandom_range(0, 40)); pb = 19'($urandom_range(0, 40)); end
        1: begin pa = 19'h7FFFF - 19'($urandom_range(0, 3)); pb = 19'($urandom_range(0, 3)); end
        default: begin pa = 19'($urandom); pb = 19'($urandom); end
      endcase
      step("random", ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
           pop, pa, pb, 3'($urandom), 1'b0, 19'd0);
    end

    aluen = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
